// File: rtl/amo_pkg.sv
// Shared definitions for the atomic-memory front end: AMO op codes, access size
// encodings and the byte-lane helper used for word/doubleword commits.
package amo_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOCAS  = 4'hA,
    AMOLr   = 4'hB,
    AMOSc   = 4'hC
  } amo_op_t;

  localparam logic [1:0] SizeWord  = 2'b10;
  localparam logic [1:0] SizeDword = 2'b11;

  // Byte-enable mask of the lane an AMO operates on, for a 64-bit bus.
  function automatic logic [7:0] lane_be(input logic dword, input logic upper);
    if (dword) return 8'hFF;
    return upper ? 8'hF0 : 8'h0F;
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO datapath: operates on the lane-aligned old value and operand,
// producing the value to commit and the CAS compare result.
module amo_alu
  import amo_pkg::*;
#(
  parameter int DataWidth = 64
) (
  input  logic [3:0]           op_i,
  input  logic                 dword_i,
  input  logic [DataWidth-1:0] operand_a_i,
  input  logic [DataWidth-1:0] operand_b_i,
  input  logic [31:0]          swap_i,
  output logic [DataWidth-1:0] result_o,
  output logic                 cas_eq_o
);

  logic [DataWidth:0]   signA, signB, unsA, unsB;
  logic [DataWidth-1:0] res;
  logic                 lessSigned, lessUnsigned;

  // Word ops compare on sign/zero-extended 32-bit values; upper bits are dropped afterwards.
  always_comb begin
    if (dword_i) begin
      signA = {operand_a_i[DataWidth-1], operand_a_i};
      signB = {operand_b_i[DataWidth-1], operand_b_i};
      unsA  = {1'b0, operand_a_i};
      unsB  = {1'b0, operand_b_i};
      cas_eq_o = (operand_a_i == operand_b_i);
    end else begin
      signA = {{(DataWidth-31){operand_a_i[31]}}, operand_a_i[31:0]};
      signB = {{(DataWidth-31){operand_b_i[31]}}, operand_b_i[31:0]};
      unsA  = {{(DataWidth-31){1'b0}}, operand_a_i[31:0]};
      unsB  = {{(DataWidth-31){1'b0}}, operand_b_i[31:0]};
      cas_eq_o = (operand_a_i[31:0] == operand_b_i[31:0]);
    end
    lessSigned   = $signed(signA) < $signed(signB);
    lessUnsigned = unsA < unsB;

    res = '0;
    case (op_i)
      AMONone: res = operand_b_i;
      AMOSwap: res = operand_b_i;
      AMOAdd:  res = operand_a_i + operand_b_i;
      AMOAnd:  res = operand_a_i & operand_b_i;
      AMOOr:   res = operand_a_i | operand_b_i;
      AMOXor:  res = operand_a_i ^ operand_b_i;
      AMOMax:  res = lessSigned ? operand_b_i : operand_a_i;
      AMOMaxu: res = lessUnsigned ? operand_b_i : operand_a_i;
      AMOMin:  res = lessSigned ? operand_a_i : operand_b_i;
      AMOMinu: res = lessUnsigned ? operand_a_i : operand_b_i;
      AMOCAS:  res = cas_eq_o ? DataWidth'(swap_i) : operand_a_i;
      AMOLr:   res = operand_a_i;
      AMOSc:   res = operand_b_i;
      default: res = '0;
    endcase

    result_o = dword_i ? res : (res & DataWidth'(64'h0000_0000_FFFF_FFFF));
  end

endmodule

// File: rtl/amo_unit_mh.sv
// Multi-hart atomic front end in front of an exclusively owned SRAM bank: plain
// traffic passes through, AMOs run as read-modify-write, LR/SC keeps one reservation per hart.
module amo_unit_mh
  import amo_pkg::*;
#(
  parameter int AddrMemWidth = 32,
  parameter int DataWidth    = 64,
  parameter int NumHarts     = 4,
  parameter int ResvGranule  = 8,
  parameter int HartIdW      = (NumHarts > 1) ? $clog2(NumHarts) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_req_i,
  output logic                      in_gnt_o,
  input  logic [AddrMemWidth-1:0]   in_add_i,
  input  logic [3:0]                in_amo_i,
  input  logic [1:0]                in_size_i,
  input  logic [HartIdW-1:0]        in_hart_id_i,
  input  logic                      in_wen_i,
  input  logic [DataWidth-1:0]      in_wdata_i,
  input  logic [DataWidth/8-1:0]    in_be_i,
  input  logic                      in_logic_in_memory_i,
  input  logic [2:0]                in_opcode_mem_i,
  input  logic [31:0]               in_asize_mem_i,
  output logic [DataWidth-1:0]      in_rdata_o,
  output logic                      in_rvalid_o,
  output logic                      out_req_o,
  input  logic                      out_gnt_i,
  output logic [AddrMemWidth-1:0]   out_add_o,
  output logic                      out_wen_o,
  output logic [DataWidth-1:0]      out_wdata_o,
  output logic [DataWidth/8-1:0]    out_be_o,
  output logic                      out_logic_in_memory_o,
  output logic [2:0]                out_opcode_mem_o,
  output logic [31:0]               out_asize_mem_o,
  input  logic [DataWidth-1:0]      out_rdata_i
);

  localparam int GranBits   = $clog2(ResvGranule);
  localparam int GranW      = AddrMemWidth - GranBits;
  localparam int BeW        = DataWidth / 8;
  localparam int LaneShift  = (DataWidth >= 64) ? 32 : 0;
  localparam int UpperBeIdx = (DataWidth >= 64) ? 4 : 0;

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StDoAmo     = 2'd1;
  localparam logic [1:0] StWriteback = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    rvalid_q, rvalid_d;
  logic [3:0]              op_q;
  logic [AddrMemWidth-1:0] addr_q;
  logic                    dword_q, upper_q;
  logic [HartIdW-1:0]      hart_q;
  logic [DataWidth-1:0]    opb_q, result_q;
  logic [31:0]             swap_q;
  logic [NumHarts-1:0]     resvValid_q, resvValid_d;
  logic [GranW-1:0]        resvGran_q [NumHarts];
  logic [GranW-1:0]        resvGran_d [NumHarts];

  logic                 accept, isAmoReq, reqDword, reqUpper;
  logic                 scOk, casEq, writeOk, writeGrant, scClear;
  logic                 setEn, storeInv, invEn;
  logic [GranW-1:0]     reqGran, amoGran, invGran;
  logic [DataWidth-1:0] reqOpB, laneA, aluResult, wrSrc, wrData, laneMaskBits;
  logic [7:0]           laneBe8;
  logic [BeW-1:0]       laneBe;

  assign accept   = (state_q == StIdle) && in_req_i && out_gnt_i;
  assign in_gnt_o = accept;
  assign isAmoReq = (in_amo_i != AMONone) && (in_amo_i != AMOLr);
  assign reqDword = (DataWidth >= 64) && (in_size_i == SizeDword);
  assign reqUpper = !reqDword && (DataWidth >= 64) && in_be_i[UpperBeIdx];
  assign reqOpB   = reqUpper ? (in_wdata_i >> LaneShift) : in_wdata_i;
  assign reqGran  = in_add_i[AddrMemWidth-1:GranBits];
  assign amoGran  = addr_q[AddrMemWidth-1:GranBits];

  assign laneA   = upper_q ? (out_rdata_i >> LaneShift) : out_rdata_i;
  assign laneBe8 = lane_be(dword_q, upper_q);
  assign laneBe  = laneBe8[BeW-1:0];
  assign wrSrc   = (state_q == StDoAmo) ? aluResult : result_q;
  assign wrData  = upper_q ? (wrSrc << LaneShift) : wrSrc;
  assign scOk    = resvValid_q[hart_q] && (resvGran_q[hart_q] == amoGran);
  assign writeOk = !((op_q == AMOSc) && !scOk) && !((op_q == AMOCAS) && !casEq);

  assign out_logic_in_memory_o = in_logic_in_memory_i;
  assign out_opcode_mem_o      = in_opcode_mem_i;
  assign out_asize_mem_o       = in_asize_mem_i;

  amo_alu #(.DataWidth(DataWidth)) u_alu (
    .op_i        (op_q),
    .dword_i     (dword_q),
    .operand_a_i (laneA),
    .operand_b_i (opb_q),
    .swap_i      (swap_q),
    .result_o    (aluResult),
    .cas_eq_o    (casEq)
  );

  always_comb begin
    laneMaskBits = '0;
    for (int b = 0; b < BeW; b++) laneMaskBits[8*b +: 8] = {8{laneBe[b]}};
  end

  // Bus muxing and FSM: idle is a feed-through, the AMO states own the bank.
  always_comb begin
    state_d     = state_q;
    writeGrant  = 1'b0;
    scClear     = 1'b0;
    out_req_o   = in_req_i;
    out_add_o   = in_add_i;
    out_wen_o   = in_wen_i && (in_amo_i == AMONone);
    out_wdata_o = in_wdata_i;
    out_be_o    = in_be_i;
    in_rdata_o  = out_rdata_i;
    in_rvalid_o = rvalid_q;
    rvalid_d    = accept && !isAmoReq && (in_amo_i == AMOLr || !in_wen_i);
    case (state_q)
      StIdle: begin
        if (accept && isAmoReq) state_d = StDoAmo;
      end
      StDoAmo: begin
        in_rvalid_o = 1'b1;
        in_rdata_o  = (op_q == AMOSc) ? (DataWidth'(!scOk) << (upper_q ? LaneShift : 0))
                                      : (out_rdata_i & laneMaskBits);
        out_req_o   = writeOk;
        out_add_o   = addr_q;
        out_wen_o   = 1'b1;
        out_be_o    = laneBe;
        out_wdata_o = wrData;
        if (!writeOk) begin
          scClear = (op_q == AMOSc);
          state_d = StIdle;
        end else if (out_gnt_i) begin
          writeGrant = 1'b1;
          state_d    = StIdle;
        end else begin
          state_d = StWriteback;
        end
      end
      StWriteback: begin
        in_rvalid_o = 1'b0;
        out_req_o   = 1'b1;
        out_add_o   = addr_q;
        out_wen_o   = 1'b1;
        out_be_o    = laneBe;
        out_wdata_o = wrData;
        if (out_gnt_i) begin
          writeGrant = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign setEn    = accept && (in_amo_i == AMOLr);
  assign storeInv = accept && in_wen_i && (in_amo_i == AMONone);
  assign invEn    = storeInv || writeGrant;
  assign invGran  = writeGrant ? amoGran : reqGran;

  // A granule write kills every matching reservation; an LR set is applied last so it wins.
  always_comb begin
    resvValid_d = resvValid_q;
    resvGran_d  = resvGran_q;
    for (int h = 0; h < NumHarts; h++) begin
      if (invEn && resvValid_q[h] && (resvGran_q[h] == invGran)) resvValid_d[h] = 1'b0;
      if (scClear && (hart_q == HartIdW'(h))) resvValid_d[h] = 1'b0;
      if (setEn && (in_hart_id_i == HartIdW'(h))) begin
        resvValid_d[h] = 1'b1;
        resvGran_d[h]  = reqGran;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rvalid_q    <= 1'b0;
      result_q    <= '0;
      op_q        <= 4'h0;
      addr_q      <= '0;
      dword_q     <= 1'b0;
      upper_q     <= 1'b0;
      hart_q      <= '0;
      opb_q       <= '0;
      swap_q      <= '0;
      resvValid_q <= '0;
      for (int h = 0; h < NumHarts; h++) resvGran_q[h] <= '0;
    end else begin
      state_q     <= state_d;
      rvalid_q    <= rvalid_d;
      resvValid_q <= resvValid_d;
      resvGran_q  <= resvGran_d;
      if (accept && isAmoReq) begin
        op_q    <= in_amo_i;
        addr_q  <= in_add_i;
        dword_q <= reqDword;
        upper_q <= reqUpper;
        hart_q  <= in_hart_id_i;
        opb_q   <= reqOpB;
        swap_q  <= in_wdata_i[LaneShift +: 32];
      end
      if (state_q == StDoAmo) result_q <= aluResult;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(setEn && invEn));
  assert property (@(posedge clk_i) disable iff (rst_i) accept |-> (in_amo_i <= AMOSc));

endmodule

// File: tb/tb_amo_unit_mh.sv
// Directed bench for amo_unit_mh: a vector table of single AMOs against a small SRAM
// model, plus hand-written backpressure, LR/SC, CAS and reset sequences.
module tb_amo_unit_mh;
  import amo_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_req_i = 1'b0;
  logic        in_gnt_o;
  logic [31:0] in_add_i = '0;
  logic [3:0]  in_amo_i = AMONone;
  logic [1:0]  in_size_i = SizeWord;
  logic [1:0]  in_hart_id_i = '0;
  logic        in_wen_i = 1'b0;
  logic [63:0] in_wdata_i = '0;
  logic [7:0]  in_be_i = '0;
  logic        in_logic_in_memory_i = 1'b1;
  logic [2:0]  in_opcode_mem_i = 3'b101;
  logic [31:0] in_asize_mem_i = 32'h0000_1234;
  logic [63:0] in_rdata_o;
  logic        in_rvalid_o;
  logic        out_req_o;
  logic        out_gnt_i = 1'b1;
  logic [31:0] out_add_o;
  logic        out_wen_o;
  logic [63:0] out_wdata_o;
  logic [7:0]  out_be_o;
  logic        out_logic_in_memory_o;
  logic [2:0]  out_opcode_mem_o;
  logic [31:0] out_asize_mem_o;
  logic [63:0] out_rdata_i;

  amo_unit_mh dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_amo_i(in_amo_i),
    .in_size_i(in_size_i), .in_hart_id_i(in_hart_id_i), .in_wen_i(in_wen_i),
    .in_wdata_i(in_wdata_i), .in_be_i(in_be_i),
    .in_logic_in_memory_i(in_logic_in_memory_i), .in_opcode_mem_i(in_opcode_mem_i),
    .in_asize_mem_i(in_asize_mem_i),
    .in_rdata_o(in_rdata_o), .in_rvalid_o(in_rvalid_o),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o), .out_wen_o(out_wen_o),
    .out_wdata_o(out_wdata_o), .out_be_o(out_be_o),
    .out_logic_in_memory_o(out_logic_in_memory_o), .out_opcode_mem_o(out_opcode_mem_o),
    .out_asize_mem_o(out_asize_mem_o), .out_rdata_i(out_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  logic [63:0] mem [64];
  logic [63:0] rdataReg = '0;
  int          writeCount = 0;

  // SRAM model: byte-enabled writes, read data one cycle after a granted read.
  always @(posedge clk_i) begin
    if (out_req_o && out_gnt_i) begin
      if (out_wen_o) begin
        for (int b = 0; b < 8; b++)
          if (out_be_o[b]) mem[out_add_o[8:3]][8*b +: 8] <= out_wdata_o[8*b +: 8];
        writeCount <= writeCount + 1;
      end else begin
        rdataReg <= mem[out_add_o[8:3]];
      end
    end
  end
  assign out_rdata_i = rdataReg;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] init;
    logic [63:0] wdata;
    logic [63:0] expRdata;
    logic [63:0] expMem;
  } vecRecord_t;

  vecRecord_t vecs [13];
  int checkCount = 0;
  int passCount = 0;
  logic lastWen, lastGnt;
  int wcBefore;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic setVec(input int i, input logic [3:0] op, input logic [1:0] size, input logic [31:0] addr,
                        input logic [7:0] be, input logic [63:0] init, input logic [63:0] wdata,
                        input logic [63:0] expRdata, input logic [63:0] expMem);
    vecs[i].op = op; vecs[i].size = size; vecs[i].addr = addr; vecs[i].be = be;
    vecs[i].init = init; vecs[i].wdata = wdata; vecs[i].expRdata = expRdata; vecs[i].expMem = expMem;
  endtask

  task automatic doStore(input logic [31:0] addr, input logic [63:0] data);
    @(posedge clk_i); #1;
    in_req_i = 1'b1; in_wen_i = 1'b1; in_amo_i = AMONone; in_size_i = SizeDword;
    in_add_i = addr; in_wdata_i = data; in_be_i = 8'hFF;
    @(posedge clk_i); #1;
    in_req_i = 1'b0; in_wen_i = 1'b0;
  endtask

  // Issue one request; on return the request was accepted and we sit 1ns past that edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] size, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [7:0] be, input logic [1:0] hart,
                               input logic wen);
    @(posedge clk_i); #1;
    in_req_i = 1'b1; in_amo_i = op; in_size_i = size; in_add_i = addr;
    in_wdata_i = wdata; in_be_i = be; in_hart_id_i = hart; in_wen_i = wen;
    @(negedge clk_i);
    lastWen = out_wen_o;
    lastGnt = in_gnt_o;
    @(posedge clk_i); #1;
    in_req_i = 1'b0; in_wen_i = 1'b0; in_amo_i = AMONone;
  endtask

  initial begin
    setVec(0,  AMOAdd,  SizeWord,  32'h10, 8'h0F, 64'h5, 64'h3, 64'h5, 64'h8);
    setVec(1,  AMOMaxu, SizeDword, 32'h18, 8'hFF, 64'hFFFF_FFFF_0000_0000, 64'h1,
           64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000);
    setVec(2,  AMOMin,  SizeWord,  32'h20, 8'hF0, 64'h0000_0003_1234_5678, 64'hFFFF_FFFE_0000_0000,
           64'h0000_0003_0000_0000, 64'hFFFF_FFFE_1234_5678);
    setVec(3,  AMOAnd,  SizeWord,  32'h28, 8'h0F, 64'hAAAA_AAAA_F0F0_1234, 64'h0FF0_FFFF,
           64'hF0F0_1234, 64'hAAAA_AAAA_00F0_1234);
    setVec(4,  AMOMax,  SizeWord,  32'h30, 8'h0F, 64'h8000_0000, 64'h1, 64'h8000_0000, 64'h1);
    setVec(5,  AMOMaxu, SizeWord,  32'h38, 8'h0F, 64'h8000_0000, 64'h1, 64'h8000_0000, 64'h8000_0000);
    setVec(6,  AMOAdd,  SizeWord,  32'h48, 8'h0F, 64'h1111_1111_FFFF_FFFF, 64'h2,
           64'hFFFF_FFFF, 64'h1111_1111_0000_0001);
    setVec(7,  AMOAdd,  SizeDword, 32'h50, 8'hFF, 64'hFFFF_FFFF, 64'h1, 64'hFFFF_FFFF, 64'h1_0000_0000);
    setVec(8,  AMOSwap, SizeWord,  32'h58, 8'hF0, 64'h1111_2222_3333_4444, 64'hDEAD_BEEF_0000_0000,
           64'h1111_2222_0000_0000, 64'hDEAD_BEEF_3333_4444);
    setVec(9,  AMOXor,  SizeWord,  32'h60, 8'h0F, 64'hFF00_FF00, 64'h0F0F_0F0F, 64'hFF00_FF00, 64'hF00F_F00F);
    setVec(10, AMOMinu, SizeDword, 32'h68, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h5);
    setVec(11, AMOMin,  SizeDword, 32'h70, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    setVec(12, AMOOr,   SizeWord,  32'h78, 8'h0F, 64'hF0, 64'hF00, 64'hF0, 64'hFF0);

    @(negedge clk_i);
    checkOutput("reset rvalid", 64'(in_rvalid_o), 64'h0);
    checkOutput("reset out_req", 64'(out_req_o), 64'h0);
    checkOutput("reset in_gnt", 64'(in_gnt_o), 64'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("lim feed", 64'(out_logic_in_memory_o), 64'h1);
    checkOutput("opcode feed", 64'(out_opcode_mem_o), 64'h5);
    checkOutput("asize feed", 64'(out_asize_mem_o), 64'h1234);

    for (int i = 0; i < 13; i++) begin
      doStore(vecs[i].addr, vecs[i].init);
      applyStimulus(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].be, 2'd0, 1'b0);
      checkOutput($sformatf("v%0d accept", i), 64'(lastGnt), 64'h1);
      @(negedge clk_i);
      checkOutput($sformatf("v%0d rvalid", i), 64'(in_rvalid_o), 64'h1);
      checkOutput($sformatf("v%0d rdata", i), in_rdata_o, vecs[i].expRdata);
      checkOutput($sformatf("v%0d wreq", i), 64'(out_req_o), 64'h1);
      checkOutput($sformatf("v%0d be", i), 64'(out_be_o), 64'(vecs[i].be));
      @(posedge clk_i); #1;
      checkOutput($sformatf("v%0d mem", i), mem[vecs[i].addr[8:3]], vecs[i].expMem);
      @(negedge clk_i);
      checkOutput($sformatf("v%0d idle rvalid", i), 64'(in_rvalid_o), 64'h0);
      checkOutput($sformatf("v%0d idle req", i), 64'(out_req_o), 64'h0);
    end

    applyStimulus(AMONone, SizeDword, 32'h10, 64'h0, 8'hFF, 2'd0, 1'b0);
    @(negedge clk_i);
    checkOutput("load rvalid", 64'(in_rvalid_o), 64'h1);
    checkOutput("load rdata", in_rdata_o, 64'h8);
    @(negedge clk_i);
    checkOutput("load rvalid drop", 64'(in_rvalid_o), 64'h0);

    // Backpressure: write held three cycles in WRITEBACK while a load waits.
    doStore(32'h90, 64'hAA);
    applyStimulus(AMOSwap, SizeWord, 32'h90, 64'h55, 8'h0F, 2'd0, 1'b0);
    out_gnt_i = 1'b0;
    in_req_i = 1'b1; in_add_i = 32'h90; in_wen_i = 1'b0; in_amo_i = AMONone;
    wcBefore = writeCount;
    @(negedge clk_i);
    checkOutput("bp rdata", in_rdata_o, 64'hAA);
    checkOutput("bp doamo gnt", 64'(in_gnt_o), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checkOutput($sformatf("bp%0d req", k), 64'(out_req_o), 64'h1);
      checkOutput($sformatf("bp%0d wdata", k), out_wdata_o, 64'h55);
      checkOutput($sformatf("bp%0d be", k), 64'(out_be_o), 64'h0F);
      checkOutput($sformatf("bp%0d addr", k), 64'(out_add_o), 64'h90);
      checkOutput($sformatf("bp%0d gnt", k), 64'(in_gnt_o), 64'h0);
      checkOutput($sformatf("bp%0d rvalid", k), 64'(in_rvalid_o), 64'h0);
    end
    out_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    in_req_i = 1'b0;
    checkOutput("bp writes", 64'(writeCount - wcBefore), 64'h1);
    checkOutput("bp mem", mem[18], 64'h55);

    // LR/SC race on one 8-byte granule.
    doStore(32'h40, 64'h0);
    applyStimulus(AMOLr, SizeWord, 32'h40, 64'h0, 8'h0F, 2'd0, 1'b0);
    @(negedge clk_i);
    checkOutput("lr0 rvalid", 64'(in_rvalid_o), 64'h1);
    applyStimulus(AMOLr, SizeWord, 32'h44, 64'h0, 8'hF0, 2'd1, 1'b0);
    wcBefore = writeCount;
    applyStimulus(AMOSc, SizeWord, 32'h44, 64'h0000_0077_0000_0000, 8'hF0, 2'd1, 1'b1);
    checkOutput("sc1 read phase wen", 64'(lastWen), 64'h0);
    @(negedge clk_i);
    checkOutput("sc1 status", in_rdata_o, 64'h0);
    checkOutput("sc1 req", 64'(out_req_o), 64'h1);
    @(posedge clk_i); #1;
    checkOutput("sc1 writes", 64'(writeCount - wcBefore), 64'h1);
    checkOutput("sc1 mem", mem[8], 64'h0000_0077_0000_0000);
    applyStimulus(AMOSc, SizeWord, 32'h40, 64'h99, 8'h0F, 2'd0, 1'b1);
    @(negedge clk_i);
    checkOutput("sc0 status", in_rdata_o, 64'h1);
    checkOutput("sc0 req", 64'(out_req_o), 64'h0);
    @(posedge clk_i); #1;
    checkOutput("sc0 writes", 64'(writeCount - wcBefore), 64'h1);
    checkOutput("sc0 mem", mem[8], 64'h0000_0077_0000_0000);

    // Compare-and-swap hit then miss.
    doStore(32'hA0, 64'h7);
    applyStimulus(AMOCAS, SizeWord, 32'hA0, {32'd9, 32'd7}, 8'h0F, 2'd0, 1'b1);
    checkOutput("cas read phase wen", 64'(lastWen), 64'h0);
    @(negedge clk_i);
    checkOutput("cas1 rdata", in_rdata_o, 64'h7);
    checkOutput("cas1 req", 64'(out_req_o), 64'h1);
    checkOutput("cas1 wdata", out_wdata_o, 64'h9);
    @(posedge clk_i); #1;
    checkOutput("cas1 mem", mem[20], 64'h9);
    applyStimulus(AMOCAS, SizeWord, 32'hA0, {32'd1, 32'd7}, 8'h0F, 2'd0, 1'b1);
    @(negedge clk_i);
    checkOutput("cas2 rdata", in_rdata_o, 64'h9);
    checkOutput("cas2 req", 64'(out_req_o), 64'h0);
    @(posedge clk_i); #1;
    checkOutput("cas2 mem", mem[20], 64'h9);

    // Reset during WRITEBACK drops the write and the reservations.
    applyStimulus(AMOLr, SizeWord, 32'hB0, 64'h0, 8'h0F, 2'd2, 1'b0);
    @(negedge clk_i);
    checkOutput("lr2 rvalid", 64'(in_rvalid_o), 64'h1);
    doStore(32'hC0, 64'h10);
    applyStimulus(AMOAdd, SizeWord, 32'hC0, 64'h1, 8'h0F, 2'd0, 1'b0);
    out_gnt_i = 1'b0;
    wcBefore = writeCount;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("wb req", 64'(out_req_o), 64'h1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst req", 64'(out_req_o), 64'h0);
    checkOutput("rst rvalid", 64'(in_rvalid_o), 64'h0);
    out_gnt_i = 1'b1;
    checkOutput("rst writes", 64'(writeCount - wcBefore), 64'h0);
    checkOutput("rst mem", mem[24], 64'h10);
    applyStimulus(AMOSc, SizeWord, 32'hB0, 64'h5, 8'h0F, 2'd2, 1'b1);
    @(negedge clk_i);
    checkOutput("sc2 status", in_rdata_o, 64'h1);
    checkOutput("sc2 req", 64'(out_req_o), 64'h0);
    @(posedge clk_i); #1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
